// File: rtl/dram_refresh_scheduler.sv
// CAS-before-RAS refresh scheduler for the Zorro II FastRAM DRAM array.
// Tracks refresh debt, issues CBR sequences on an idle bus, and holds off accesses when the debt is full.
module dram_refresh_scheduler #(
  parameter int REFRESH_INTERVAL = 109,
  parameter int MAX_PENDING      = 4,
  parameter int CAS_CYCLES       = 1,
  parameter int RAS_CYCLES       = 2,
  parameter int PRE_CYCLES       = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       bus_idle,
  input  logic       access_busy,
  output logic       refresh_cas,
  output logic       refresh_ras,
  output logic       refresh_busy,
  output logic       hold_access,
  output logic [2:0] pending,
  output logic       missed
);

  localparam int CW = $clog2(REFRESH_INTERVAL);
  localparam int DW = 4;

  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_INTERVAL - 1);
  localparam logic [2:0]    PEND_MAX = 3'(MAX_PENDING);
  localparam logic [DW-1:0] CAS_LD   = DW'(CAS_CYCLES - 1);
  localparam logic [DW-1:0] RAS_LD   = DW'(RAS_CYCLES - 1);
  localparam logic [DW-1:0] PRE_LD   = DW'(PRE_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CAS  = 2'd1;
  localparam logic [1:0] S_RAS  = 2'd2;
  localparam logic [1:0] S_PRE  = 2'd3;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_state;
  logic [DW-1:0] r_dcnt;
  logic [2:0]    r_pending;
  logic          r_missed;
  logic          r_cas;
  logic          r_ras;
  logic          r_busy;
  logic          r_hold;

  logic          w_tick;
  logic          w_start;
  logic          w_miss;
  logic [2:0]    w_pending_nxt;
  logic [1:0]    w_state_nxt;
  logic [DW-1:0] w_dcnt_nxt;

  // Once the debt is full, a refresh wins over a waiting bus master as soon as no access is in flight.
  always_comb begin
    w_tick  = (r_cnt == CNT_LAST);
    w_start = (r_state == S_IDLE) && (r_pending != 3'd0) && !access_busy &&
              (bus_idle || (r_pending == PEND_MAX));
    w_miss  = w_tick && !w_start && (r_pending == PEND_MAX);
  end

  // Refresh debt: ticks add, starts remove, saturating at the limit.
  always_comb begin
    w_pending_nxt = r_pending;
    case ({w_tick, w_start})
      2'b10: begin
        if (r_pending == PEND_MAX) begin
          w_pending_nxt = r_pending;
        end else begin
          w_pending_nxt = r_pending + 3'd1;
        end
      end
      2'b01:   w_pending_nxt = r_pending - 3'd1;
      default: w_pending_nxt = r_pending;
    endcase
  end

  // CBR sequencer; each phase loads its down-counter on entry and leaves when it reaches zero.
  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_CAS;
          w_dcnt_nxt  = CAS_LD;
        end else begin
          w_state_nxt = S_IDLE;
          w_dcnt_nxt  = {DW{1'b0}};
        end
      end
      S_CAS: begin
        if (r_dcnt == {DW{1'b0}}) begin
          w_state_nxt = S_RAS;
          w_dcnt_nxt  = RAS_LD;
        end else begin
          w_dcnt_nxt  = r_dcnt - {{(DW-1){1'b0}}, 1'b1};
        end
      end
      S_RAS: begin
        if (r_dcnt == {DW{1'b0}}) begin
          w_state_nxt = S_PRE;
          w_dcnt_nxt  = PRE_LD;
        end else begin
          w_dcnt_nxt  = r_dcnt - {{(DW-1){1'b0}}, 1'b1};
        end
      end
      S_PRE: begin
        if (r_dcnt == {DW{1'b0}}) begin
          w_state_nxt = S_IDLE;
          w_dcnt_nxt  = {DW{1'b0}};
        end else begin
          w_dcnt_nxt  = r_dcnt - {{(DW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_dcnt_nxt  = {DW{1'b0}};
      end
    endcase
  end

  // Outputs are registered from next-state so they line up with the state they describe.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt     <= {CW{1'b0}};
      r_state   <= S_IDLE;
      r_dcnt    <= {DW{1'b0}};
      r_pending <= 3'd0;
      r_missed  <= 1'b0;
      r_cas     <= 1'b0;
      r_ras     <= 1'b0;
      r_busy    <= 1'b0;
      r_hold    <= 1'b0;
    end else begin
      r_cnt     <= w_tick ? {CW{1'b0}} : r_cnt + {{(CW-1){1'b0}}, 1'b1};
      r_state   <= w_state_nxt;
      r_dcnt    <= w_dcnt_nxt;
      r_pending <= w_pending_nxt;
      r_missed  <= r_missed | w_miss;
      r_cas     <= (w_state_nxt == S_CAS) || (w_state_nxt == S_RAS);
      r_ras     <= (w_state_nxt == S_RAS);
      r_busy    <= (w_state_nxt != S_IDLE);
      r_hold    <= (w_pending_nxt == PEND_MAX) || (w_state_nxt != S_IDLE);
    end
  end

  assign refresh_cas  = r_cas;
  assign refresh_ras  = r_ras;
  assign refresh_busy = r_busy;
  assign hold_access  = r_hold;
  assign pending      = r_pending;
  assign missed       = r_missed;

endmodule

// File: tb/tb_dram_refresh_scheduler.sv
// Directed bench for dram_refresh_scheduler; cycle numbers count CLK edges since reset release.
module tb_dram_refresh_scheduler;

  logic       CLK;
  logic       RESET;
  logic       bus_idle;
  logic       access_busy;
  logic       refresh_cas;
  logic       refresh_ras;
  logic       refresh_busy;
  logic       hold_access;
  logic [2:0] pending;
  logic       missed;

  int checks;
  int failures;
  int cyc;

  dram_refresh_scheduler dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .bus_idle     (bus_idle),
    .access_busy  (access_busy),
    .refresh_cas  (refresh_cas),
    .refresh_ras  (refresh_ras),
    .refresh_busy (refresh_busy),
    .hold_access  (hold_access),
    .pending      (pending),
    .missed       (missed)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic goto(input int target);
    while (cyc < target) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b1;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
    RESET = 1'b0;
    cyc = 0;
  endtask

  task automatic check_seq(input string tag, input logic c, input logic r, input logic b,
                           input logic h, input logic [2:0] p);
    check({tag, ".cas"},  {7'd0, refresh_cas},  {7'd0, c});
    check({tag, ".ras"},  {7'd0, refresh_ras},  {7'd0, r});
    check({tag, ".busy"}, {7'd0, refresh_busy}, {7'd0, b});
    check({tag, ".hold"}, {7'd0, hold_access},  {7'd0, h});
    check({tag, ".pend"}, {5'd0, pending},      {5'd0, p});
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    cyc         = 0;
    RESET       = 1'b1;
    bus_idle    = 1'b1;
    access_busy = 1'b0;

    // Reset and first refresh on an idle bus
    do_reset(3);
    check_seq("rst", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    check("rst.missed", {7'd0, missed}, 8'd0);
    goto(108); check_seq("c108", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    goto(109); check_seq("c109", 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    goto(110); check_seq("c110", 1'b1, 1'b0, 1'b1, 1'b1, 3'd0);
    goto(111); check_seq("c111", 1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
    goto(112); check_seq("c112", 1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
    goto(113); check_seq("c113", 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
    goto(114); check_seq("c114", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    // Busy bus accumulates three refreshes, then drains back-to-back
    bus_idle = 1'b0;
    goto(464); check_seq("busy464", 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
    bus_idle = 1'b1;
    goto(465); check_seq("drain465", 1'b1, 1'b0, 1'b1, 1'b1, 3'd2);
    goto(468); check_seq("drain468", 1'b0, 1'b0, 1'b1, 1'b1, 3'd2);
    goto(470); check_seq("drain470", 1'b1, 1'b0, 1'b1, 1'b1, 3'd1);
    goto(475); check_seq("drain475", 1'b1, 1'b0, 1'b1, 1'b1, 3'd0);
    goto(479); check_seq("drain479", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    // Saturation forces an urgent refresh with the bus still busy
    bus_idle = 1'b0;
    do_reset(2);
    goto(435); check_seq("sat435", 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
    goto(436); check_seq("sat436", 1'b0, 1'b0, 1'b0, 1'b1, 3'd4);
    goto(437); check_seq("sat437", 1'b1, 1'b0, 1'b1, 1'b1, 3'd3);
    goto(440); check_seq("sat440", 1'b0, 1'b0, 1'b1, 1'b1, 3'd3);
    goto(441); check_seq("sat441", 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
    check("sat.missed", {7'd0, missed}, 8'd0);

    // Access held busy past the fifth tick sets missed
    bus_idle    = 1'b1;
    access_busy = 1'b1;
    do_reset(2);
    goto(544); check_seq("miss544", 1'b0, 1'b0, 1'b0, 1'b1, 3'd4);
    check("miss544.missed", {7'd0, missed}, 8'd0);
    goto(545); check_seq("miss545", 1'b0, 1'b0, 1'b0, 1'b1, 3'd4);
    check("miss545.missed", {7'd0, missed}, 8'd1);
    goto(600);
    access_busy = 1'b0;
    goto(601); check_seq("miss601", 1'b1, 1'b0, 1'b1, 1'b1, 3'd3);
    goto(616); check_seq("miss616", 1'b1, 1'b0, 1'b1, 1'b1, 3'd0);
    goto(620); check_seq("miss620", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    check("miss620.missed", {7'd0, missed}, 8'd1);
    do_reset(1);
    check("miss.cleared", {7'd0, missed}, 8'd0);

    // Tick and start in the same cycle leave pending unchanged
    bus_idle = 1'b0;
    do_reset(1);
    goto(217); check_seq("sim217", 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    bus_idle = 1'b1;
    goto(218); check_seq("sim218", 1'b1, 1'b0, 1'b1, 1'b1, 3'd1);
    goto(221); check_seq("sim221", 1'b0, 1'b0, 1'b1, 1'b1, 3'd1);
    goto(223); check_seq("sim223", 1'b1, 1'b0, 1'b1, 1'b1, 3'd0);

    // Reset during RAS aborts the sequence and restarts the interval
    goto(224); check_seq("abort224", 1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
    do_reset(1);
    check_seq("abort.rst", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    goto(108); check_seq("abort108", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    goto(109); check_seq("abort109", 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    goto(110); check_seq("abort110", 1'b1, 1'b0, 1'b1, 1'b1, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
